// File: rtl/proc_pkg.sv
// Shared types and constants for the lab03 multi-cycle control unit.
package proc_pkg;

  localparam int NREG  = 8;
  localparam int SEL_W = 4;
  localparam int IW    = 16;
  localparam int RW    = $clog2(NREG);

  // Instruction field positions: [op:3][rX:RW][rY:RW][ignored]
  localparam int OP_HI = IW - 1;
  localparam int RX_HI = IW - 4;
  localparam int RY_HI = IW - 4 - RW;

  // Bus mux select encoding
  localparam logic [SEL_W-1:0] SEL_G  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_R0 = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_A  = SEL_W'(NREG + 1);

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

  // Only the decoded fields of the instruction register are kept.
  typedef struct packed {
    op_t           op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
  } ir_t;

  // Bus select that puts general register r on the bus.
  function automatic logic [SEL_W-1:0] sel_reg(input logic [RW-1:0] r);
    return SEL_R0 + SEL_W'(r);
  endfunction

  // One-hot write enable for general register r.
  function automatic logic [NREG-1:0] reg_onehot(input logic [RW-1:0] r);
    return NREG'(1) << r;
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Instruction handshake plus datapath control bundle of the control unit.
interface proc_ctrl_if
  import proc_pkg::*;
();
  logic             instr_valid;
  logic             instr_ready;
  logic [IW-1:0]    instr_word;
  logic [SEL_W-1:0] bus_sel;
  logic [NREG-1:0]  r_in;
  logic             a_in;
  logic             a_src_din;
  logic             g_in;
  logic             alu_sub;
  logic             done;
  logic             illegal;

  // Instruction source / datapath observer side
  modport master (
    output instr_valid, instr_word,
    input  instr_ready, bus_sel, r_in, a_in, a_src_din, g_in, alu_sub, done, illegal
  );

  // Control unit side
  modport slave (
    input  instr_valid, instr_word,
    output instr_ready, bus_sel, r_in, a_in, a_src_din, g_in, alu_sub, done, illegal
  );
endinterface

// File: rtl/proc_ctrl_decode.sv
// Combinational decode of (state, IR) into the datapath control vector.
module proc_ctrl_decode
  import proc_pkg::*;
(
  input  state_t           state,
  input  ir_t              ir,
  output logic [SEL_W-1:0] bus_sel,
  output logic [NREG-1:0]  r_in,
  output logic             a_in,
  output logic             a_src_din,
  output logic             g_in,
  output logic             alu_sub,
  output logic             done,
  output logic             illegal
);

  // Moore decode: each step drives only the enables it needs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus_sel   = SEL_G;
    r_in      = '0;
    a_in      = 1'b0;
    a_src_din = 1'b0;
    g_in      = 1'b0;
    alu_sub   = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_T1: begin
        case (ir.op)
          OP_MV: begin
            bus_sel = sel_reg(ir.ry);
            r_in    = reg_onehot(ir.rx);
            done    = 1'b1;
          end
          OP_MVI: begin
            a_in      = 1'b1;
            a_src_din = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = sel_reg(ir.rx);
            a_in    = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      ST_T2: begin
        case (ir.op)
          OP_MVI: begin
            bus_sel = SEL_A;
            r_in    = reg_onehot(ir.rx);
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel = sel_reg(ir.ry);
            g_in    = 1'b1;
            alu_sub = (ir.op == OP_SUB);
          end
          default: ;
        endcase
      end
      ST_T3: begin
        if (ir.op == OP_ADD || ir.op == OP_SUB) begin
          bus_sel = SEL_G;
          r_in    = reg_onehot(ir.rx);
          done    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit: state register, instruction register, step sequencing.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  proc_ctrl_if.slave bus
);

  state_t state, state_nx;
  ir_t    ir;
  logic   accept;

  // Low instruction bits carry no meaning for this unit.
  logic   unused_ir_lsbs;
  assign unused_ir_lsbs = ^bus.instr_word[RY_HI-RW:0];

  assign bus.instr_ready = (state == ST_IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;

  // State and instruction register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments; the async reset clears IR too.
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ir.op <= op_t'(bus.instr_word[OP_HI -: 3]);
        ir.rx <= bus.instr_word[RX_HI -: RW];
        ir.ry <= bus.instr_word[RY_HI -: RW];
      end
    end
  end

  // Next step: leave for IDLE on the step that signals done.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_T1;
      ST_T1:   state_nx = bus.done ? ST_IDLE : ST_T2;
      ST_T2:   state_nx = bus.done ? ST_IDLE : ST_T3;
      default: state_nx = ST_IDLE;
    endcase
  end

  proc_ctrl_decode u_decode (
    .state     (state),
    .ir        (ir),
    .bus_sel   (bus.bus_sel),
    .r_in      (bus.r_in),
    .a_in      (bus.a_in),
    .a_src_din (bus.a_src_din),
    .g_in      (bus.g_in),
    .alu_sub   (bus.alu_sub),
    .done      (bus.done),
    .illegal   (bus.illegal)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed table, corner sequences, random words.
module tb_proc_ctrl;

  typedef struct packed {
    logic       ready;
    logic [3:0] sel;
    logic [7:0] rin;
    logic       a;
    logic       asrc;
    logic       g;
    logic       sub;
    logic       done;
    logic       ill;
  } out_t;

  typedef struct {
    logic [15:0] word;
    int          steps;
    logic [3:0]  last_sel;
    logic [7:0]  last_rin;
    logic        ill;
  } vec_t;

  localparam out_t IDLE_V = '{ready: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  proc_ctrl_if ifc ();

  proc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.ready = ifc.instr_ready;
    o.sel   = ifc.bus_sel;
    o.rin   = ifc.r_in;
    o.a     = ifc.a_in;
    o.asrc  = ifc.a_src_din;
    o.g     = ifc.g_in;
    o.sub   = ifc.alu_sub;
    o.done  = ifc.done;
    o.ill   = ifc.illegal;
    return o;
  endfunction

  function automatic out_t mk(input logic [3:0] sel, input logic [7:0] rin, input logic a,
                              input logic asrc, input logic g, input logic sub,
                              input logic dn, input logic ill);
    out_t o;
    o = '{ready: 1'b0, sel: sel, rin: rin, a: a, asrc: asrc, g: g, sub: sub, done: dn, ill: ill};
    return o;
  endfunction

  // Reference: list of per-step control vectors an instruction word must produce.
  task automatic model(input logic [15:0] w, output out_t e[3], output int n);
    int op, rx, ry;
    logic [7:0] rxh;
    op  = int'(w[15:13]);
    rx  = int'(w[12:10]);
    ry  = int'(w[9:7]);
    rxh = 8'(1 << rx);
    e[0] = IDLE_V; e[1] = IDLE_V; e[2] = IDLE_V;
    case (op)
      0: begin n = 1; e[0] = mk(4'(ry + 1), rxh, 0, 0, 0, 0, 1, 0); end
      1: begin
        n = 2;
        e[0] = mk(4'd0, 8'd0, 1, 1, 0, 0, 0, 0);
        e[1] = mk(4'd9, rxh, 0, 0, 0, 0, 1, 0);
      end
      2, 3: begin
        n = 3;
        e[0] = mk(4'(rx + 1), 8'd0, 1, 0, 0, 0, 0, 0);
        e[1] = mk(4'(ry + 1), 8'd0, 0, 0, 1, (op == 3), 0, 0);
        e[2] = mk(4'd0, rxh, 0, 0, 0, 0, 1, 0);
      end
      default: begin n = 1; e[0] = mk(4'd0, 8'd0, 0, 0, 0, 0, 1, 1); end
    endcase
  endtask

  // Issue one word from IDLE, compare every step, and report what was observed at done.
  task automatic run_instr(input logic [15:0] w, output int steps, output logic [3:0] lsel,
                           output logic [7:0] lrin, output logic lill);
    out_t e[3];
    out_t got;
    int   n;
    model(w, e, n);
    steps = 0; lsel = '0; lrin = '0; lill = 1'b0;
    @(negedge clk);
    check($sformatf("idle_before_%h", w), 32'(dut_out()), 32'(IDLE_V));
    ifc.instr_valid = 1'b1;
    ifc.instr_word  = w;
    @(posedge clk); #1;
    ifc.instr_valid = 1'(($urandom_range(0, 1)));
    ifc.instr_word  = 16'($urandom);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = dut_out();
      check($sformatf("step%0d_%h", c + 1, w), 32'(got), 32'((c < n) ? e[c] : IDLE_V));
      @(posedge clk); #1;
      if (got.done) begin
        steps = c + 1; lsel = got.sel; lrin = got.rin; lill = got.ill;
        ifc.instr_valid = 1'b0;
        break;
      end
      ifc.instr_valid = 1'(($urandom_range(0, 1)));
    end
    ifc.instr_valid = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    int steps;
    logic [3:0] lsel;
    logic [7:0] lrin;
    logic lill;

    tbl[0] = '{16'h3400, 2, 4'd9, 8'h20, 1'b0};  // mvi R5
    tbl[1] = '{16'h4500, 3, 4'd0, 8'h02, 1'b0};  // add R1,R2
    tbl[2] = '{16'h6500, 3, 4'd0, 8'h02, 1'b0};  // sub R1,R2
    tbl[3] = '{16'h0380, 1, 4'd8, 8'h01, 1'b0};  // mv R0,R7
    tbl[4] = '{16'hE000, 1, 4'd0, 8'h00, 1'b1};  // op 111
    tbl[5] = '{16'h4D80, 3, 4'd0, 8'h08, 1'b0};  // add R3,R3
    tbl[6] = '{16'h0900, 1, 4'd3, 8'h04, 1'b0};  // mv R2,R2
    tbl[7] = '{16'h8000, 1, 4'd0, 8'h00, 1'b1};  // op 100
    tbl[8] = '{16'h3C00, 2, 4'd9, 8'h80, 1'b0};  // mvi R7

    // Reset held with a valid word offered: idle, nothing captured.
    ifc.instr_valid = 1'b1;
    ifc.instr_word  = 16'h0380;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(dut_out()), 32'(IDLE_V));
    ifc.instr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("after_release_idle", 32'(dut_out()), 32'(IDLE_V));
    end

    // Directed table.
    foreach (tbl[i]) begin
      run_instr(tbl[i].word, steps, lsel, lrin, lill);
      check($sformatf("table_%h", tbl[i].word), {steps[7:0], lsel, lrin, lill},
            {tbl[i].steps[7:0], tbl[i].last_sel, tbl[i].last_rin, tbl[i].ill});
    end

    // Back-to-back mv R0,R7 with valid held high: accept every second cycle.
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_word  = 16'h0380;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_cycle%0d", k), 32'(dut_out()),
            32'((k % 2 == 0) ? IDLE_V : mk(4'd8, 8'h01, 0, 0, 0, 0, 1, 0)));
      @(negedge clk);
    end
    ifc.instr_valid = 1'b0;

    // Reset pulsed during T2 of add: outputs drop at once, no done.
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_word  = 16'h4500;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_in_t2", 32'(dut_out()), 32'(mk(4'd3, 8'd0, 0, 0, 1, 0, 0, 0)));
    #1 rst_n = 1'b0;
    #1 check("abort_async", 32'(dut_out()), 32'(IDLE_V));
    @(posedge clk);
    @(negedge clk);
    check("abort_held", 32'(dut_out()), 32'(IDLE_V));
    rst_n = 1'b1;
    run_instr(16'h6500, steps, lsel, lrin, lill);
    check("after_abort_sub", {steps[7:0], lsel, lrin, lill}, {8'd3, 4'd0, 8'h02, 1'b0});

    // Random words, with random idle gaps.
    for (int r = 0; r < 60; r++) begin
      logic [15:0] w;
      w = 16'($urandom);
      run_instr(w, steps, lsel, lrin, lill);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_gap_idle", 32'(dut_out()), 32'(IDLE_V));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
